// File: rtl/des_perm_engine.sv
// Registered DES permutation engine (IP, FP, E, P, PC-1, PC-2) behind a valid/ready FIFO output buffer.
// Optional: define DES_PERM_ERRCNT_EN to add a saturating illegal-mode counter on err_count.
module des_perm_engine #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [63:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_mode,
    output logic [63:0]       out_data,
    output logic              out_err
`ifdef DES_PERM_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]  err_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] ONE_OCC   = OCC_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [2:0] MODE_IP  = 3'd0;
    localparam logic [2:0] MODE_FP  = 3'd1;
    localparam logic [2:0] MODE_E   = 3'd2;
    localparam logic [2:0] MODE_P   = 3'd3;
    localparam logic [2:0] MODE_PC1 = 3'd4;
    localparam logic [2:0] MODE_PC2 = 3'd5;

    // FIPS 46 tables, 1-based and MSB-first: entry j names the source bit for output position j+1.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } buf_state_e;

    buf_state_e       stateQ, stateD;
    logic [OCC_W-1:0] countQ, countD;
    logic [PTR_W-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
    logic [63:0]      dataQ [FIFO_DEPTH];
    logic [2:0]       modeQ [FIFO_DEPTH];
    logic             errQ  [FIFO_DEPTH];

    logic [63:0] ipRes, fpRes;
    logic [47:0] eRes, pc2Res;
    logic [31:0] pRes;
    logic [55:0] pc1Res;
    logic [63:0] permD;
    logic        errD;
    logic        push, pop;

    // Each table is pure wiring; an n-bit field takes source bit k from in_data[n-k].
    for (genvar g = 0; g < 64; g++) begin : g_ip_fp
        assign ipRes[63 - g] = in_data[64 - IP_T[g]];
        assign fpRes[63 - g] = in_data[64 - FP_T[g]];
    end
    for (genvar g = 0; g < 48; g++) begin : g_e_pc2
        assign eRes[47 - g]   = in_data[32 - E_T[g]];
        assign pc2Res[47 - g] = in_data[56 - PC2_T[g]];
    end
    for (genvar g = 0; g < 32; g++) begin : g_p
        assign pRes[31 - g] = in_data[32 - P_T[g]];
    end
    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign pc1Res[55 - g] = in_data[64 - PC1_T[g]];
    end

    always_comb begin
        permD = '0;
        errD  = 1'b0;
        case (in_mode)
            MODE_IP:  permD = ipRes;
            MODE_FP:  permD = fpRes;
            MODE_E:   permD = {16'b0, eRes};
            MODE_P:   permD = {32'b0, pRes};
            MODE_PC1: permD = {8'b0, pc1Res};
            MODE_PC2: permD = {16'b0, pc2Res};
            default:  errD  = 1'b1;
        endcase
    end

    assign in_ready  = (stateQ != ST_FULL);
    assign out_valid = (stateQ != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        stateD = stateQ;
        countD = countQ;
        wrPtrD = push ? nextPtr(wrPtrQ) : wrPtrQ;
        rdPtrD = pop  ? nextPtr(rdPtrQ) : rdPtrQ;
        if (push && !pop) begin
            countD = countQ + ONE_OCC;
        end else if (pop && !push) begin
            countD = countQ - ONE_OCC;
        end
        case (stateQ)
            ST_EMPTY: begin
                if (push) begin
                    stateD = (DEPTH_OCC == ONE_OCC) ? ST_FULL : ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (push && !pop && (countQ == DEPTH_OCC - ONE_OCC)) begin
                    stateD = ST_FULL;
                end else if (pop && !push && (countQ == ONE_OCC)) begin
                    stateD = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    stateD = (DEPTH_OCC == ONE_OCC) ? ST_EMPTY : ST_PARTIAL;
                end
            end
            default: stateD = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ST_EMPTY;
            countQ <= '0;
            wrPtrQ <= '0;
            rdPtrQ <= '0;
        end else begin
            stateQ <= stateD;
            countQ <= countD;
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
        end
    end

    // Storage is cleared on reset so the head reads as all-zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dataQ[i] <= '0;
                modeQ[i] <= '0;
                errQ[i]  <= 1'b0;
            end
        end else if (push) begin
            dataQ[wrPtrQ] <= permD;
            modeQ[wrPtrQ] <= in_mode;
            errQ[wrPtrQ]  <= errD;
        end
    end

    assign out_data = dataQ[rdPtrQ];
    assign out_mode = modeQ[rdPtrQ];
    assign out_err  = errQ[rdPtrQ];

`ifdef DES_PERM_ERRCNT_EN
    logic [CNT_W-1:0] errCntQ, errCntD;

    always_comb begin
        errCntD = errCntQ;
        if (push && errD && !(&errCntQ)) begin
            errCntD = errCntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCntQ <= '0;
        end else begin
            errCntQ <= errCntD;
        end
    end

    assign err_count = errCntQ;
`else
`endif

endmodule

// File: tb/tb_des_perm_engine.sv
// Self-checking bench for des_perm_engine: directed table vectors, randomized traffic against a
// table-driven reference model, backpressure and asynchronous mid-burst reset.
module tb_des_perm_engine;

    localparam int DEPTH = 2;
    localparam int CW    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  in_mode, out_mode;
    logic [63:0] in_data, out_data;
`ifdef DES_PERM_ERRCNT_EN
    logic [CW-1:0] err_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference tables; FP and E are derived at run time rather than copied.
    int IP_T[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                     62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int P_T[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    int PC1_T[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int PC2_T[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int FP_T[$];
    int E_T[$];

    des_perm_engine #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode (out_mode),
        .out_data (out_data),
        .out_err  (out_err)
`ifdef DES_PERM_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // FP is the inverse of IP; E repeats 4-bit groups with one neighbour on each side.
    task automatic buildDerivedTables();
        FP_T.delete();
        E_T.delete();
        for (int j = 0; j < 64; j++) FP_T.push_back(0);
        for (int j = 0; j < 64; j++) FP_T[IP_T[j] - 1] = j + 1;
        for (int j = 0; j < 48; j++) E_T.push_back(((4 * (j / 6) + (j % 6) - 1 + 32) % 32) + 1);
    endtask

    function automatic logic [63:0] permRef(input logic [63:0] d, input int n, input int tbl[$]);
        logic [63:0] r = '0;
        int m = tbl.size();
        for (int j = 0; j < m; j++) r[m - 1 - j] = d[n - tbl[j]];
        return r;
    endfunction

    function automatic logic [63:0] modelData(input logic [2:0] m, input logic [63:0] d);
        case (m)
            3'd0:    return permRef(d, 64, IP_T);
            3'd1:    return permRef(d, 64, FP_T);
            3'd2:    return permRef(d, 32, E_T);
            3'd3:    return permRef(d, 32, P_T);
            3'd4:    return permRef(d, 64, PC1_T);
            3'd5:    return permRef(d, 56, PC2_T);
            default: return 64'd0;
        endcase
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] m, input logic [63:0] d, input logic e);
        logic [68:0] obs, exp;
        obs = {out_valid, out_mode, out_err, out_data};
        exp = {1'b1, m, e, d};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed valid=%b mode=%0d err=%b data=%h expected valid=1 mode=%0d err=%b data=%h",
                   tag, out_valid, out_mode, out_err, out_data, m, e, d);
        end
    endtask

    // Called one time unit after a rising edge; returns one time unit after the accepting edge.
    task automatic applyStimulus(input logic [2:0] m, input logic [63:0] d);
        int waitCycles = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        while (in_ready !== 1'b1 && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        vectors++;
        assert (in_ready === 1'b1) else begin
            miscompares++;
            $error("[TB] FAIL accept_timeout: observed in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mode  = 3'($urandom);
        in_data  = {$urandom, $urandom};
    endtask

    task automatic popHead();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [2:0]  m, xm;
        logic [63:0] d, v, ipv, xd;
        logic [2:0]  bm [DEPTH];
        logic [63:0] bd [DEPTH];

        buildDerivedTables();
        rst_n = 1'b0; in_valid = 1'b0; in_mode = '0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        checkVal("reset_out_valid", 64'(out_valid), 64'd0);
        checkVal("reset_in_ready",  64'(in_ready),  64'd1);
        checkVal("reset_out_data",  out_data,       64'd0);
        checkVal("reset_out_mode",  64'(out_mode),  64'd0);
        checkVal("reset_out_err",   64'(out_err),   64'd0);
`ifdef DES_PERM_ERRCNT_EN
        checkVal("reset_err_count", 64'(err_count), 64'd0);
`endif

        applyStimulus(3'd0, 64'h1);
        checkOutput("ip_unit", 3'd0, 64'h0000008000000000, 1'b0);
        popHead();
        checkVal("ip_popped_empty", 64'(out_valid), 64'd0);

        applyStimulus(3'd1, 64'h0000008000000000);
        checkOutput("fp_unit", 3'd1, 64'h1, 1'b0);
        popHead();

        applyStimulus(3'd2, 64'h00000001);
        checkOutput("e_unit", 3'd2, 64'h0000800000000002, 1'b0);
        popHead();

        applyStimulus(3'd3, 64'h80000000);
        checkOutput("p_unit", 3'd3, 64'h00800000, 1'b0);
        popHead();

        applyStimulus(3'd4, 64'h1);
        checkOutput("pc1_parity", 3'd4, 64'h0, 1'b0);
        popHead();

        applyStimulus(3'd6, '1);
        checkOutput("illegal_6", 3'd6, 64'h0, 1'b1);
`ifdef DES_PERM_ERRCNT_EN
        checkVal("err_count_1", 64'(err_count), 64'd1);
`endif
        popHead();

        applyStimulus(3'd7, 64'h0123456789abcdef);
        checkOutput("illegal_7", 3'd7, 64'h0, 1'b1);
`ifdef DES_PERM_ERRCNT_EN
        checkVal("err_count_2", 64'(err_count), 64'd2);
`endif
        popHead();

        for (int i = 0; i < 8; i++) begin
            v = {$urandom, $urandom};
            applyStimulus(3'd0, v);
            checkOutput($sformatf("rt_ip_%0d", i), 3'd0, modelData(3'd0, v), 1'b0);
            ipv = out_data;
            popHead();
            applyStimulus(3'd1, ipv);
            checkOutput($sformatf("rt_fp_%0d", i), 3'd1, v, 1'b0);
            popHead();
        end

        for (int i = 0; i < 40; i++) begin
            m = 3'($urandom_range(0, 7));
            d = {$urandom, $urandom};
            applyStimulus(m, d);
            checkOutput($sformatf("rand_%0d", i), m, modelData(m, d), (m > 3'd5));
            popHead();
        end

        for (int i = 0; i < DEPTH; i++) begin
            bm[i] = 3'($urandom_range(0, 5));
            bd[i] = {$urandom, $urandom};
            applyStimulus(bm[i], bd[i]);
        end
        checkVal("bp_full_in_ready", 64'(in_ready), 64'd0);
        xm = 3'd2;
        xd = {$urandom, $urandom};
        in_valid = 1'b1; in_mode = xm; in_data = xd;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkVal($sformatf("bp_held_off_%0d", i), 64'(in_ready), 64'd0);
            checkOutput($sformatf("bp_head_steady_%0d", i), bm[0], modelData(bm[0], bd[0]), 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkVal("bp_ready_after_pop", 64'(in_ready), 64'd1);
        checkOutput("bp_drain_order", bm[1], modelData(bm[1], bd[1]), 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp_push_pop_same_edge", xm, modelData(xm, xd), 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkVal("bp_drained_empty", 64'(out_valid), 64'd0);

        applyStimulus(3'd0, {$urandom, $urandom});
        applyStimulus(3'd3, {$urandom, $urandom});
        checkVal("mid_two_entries_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkVal("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkVal("mid_rst_out_data",  out_data,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkVal("post_rst_out_valid", 64'(out_valid), 64'd0);
        checkVal("post_rst_in_ready",  64'(in_ready),  64'd1);
`ifdef DES_PERM_ERRCNT_EN
        checkVal("post_rst_err_count", 64'(err_count), 64'd0);
`endif
        v = {$urandom, $urandom};
        applyStimulus(3'd0, v);
        checkOutput("post_rst_ip", 3'd0, modelData(3'd0, v), 1'b0);
        popHead();
        checkVal("post_rst_no_stale", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/des_perm_engine.md
Name: des_perm_engine

Overview:
- Mode-selectable, registered DES permutation unit. One instance covers IP, IP^-1 (FP), E expansion, P, PC-1 and PC-2, selected per transaction.
- Uses valid/ready handshakes on input and output, with an output buffer of parametrised depth.
- Sits between the round/key-schedule datapath and its controllers, replacing per-table combinational permute blocks.

Parameters:
- FIFO_DEPTH, 2, output buffer entries (power of two, ≥1).
- CNT_W, 8, width of the optional error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  engine can accept this cycle.
- in_mode  input  3  0=IP, 1=FP, 2=E, 3=P, 4=PC1, 5=PC2, 6/7 illegal.
- in_data  input  64  source bits, right-aligned.
- out_valid  output  1  buffer head valid.
- out_ready  input  1  consumer accepts head.
- out_mode  output  3  mode echoed with the result.
- out_data  output  64  permuted result, right-aligned, upper bits zero.
- out_err  output  1  head entry was an illegal mode.
- err_count  output  CNT_W  present only with DES_PERM_ERRCNT_EN.

Behaviour:
- Bit numbering: tables use FIPS 46 1-based, MSB-first numbering. For an n-bit field, table bit k is in_data[n-k]. Output position j of an m-bit result is out_data[m-j].
- Widths (in -> out):
  - IP 64->64, FP 64->64.
  - E 32->48, P 32->32.
  - PC1 64->56 (parity bits 8,16..64 dropped).
  - PC2 56->48 (bits 9,18,22,25,35,38,43,54 dropped).
- Input bits above n are ignored.
- Illegal mode: out_data=0, out_err=1, entry still buffered and emitted.
- Accept when in_valid && in_ready. Permutation computed combinationally, result written into the buffer at the accept edge.
- in_ready = !full. in_ready does not depend on out_ready in the same cycle.
- Latency: accepted in cycle t → out_valid=1 in cycle t+1 if the buffer was empty.
- Pop when out_valid && out_ready.
- Simultaneous push and pop when full: push refused (in_ready=0). Pop proceeds.
- Simultaneous push and pop when not full: both occur; occupancy unchanged.
- Outputs hold steady while out_valid && !out_ready.
- Order preserved: FIFO.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- Buffer states: EMPTY (count=0), PARTIAL, FULL (count=FIFO_DEPTH).
  - EMPTY→PARTIAL/FULL on push without pop.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop of the last entry without push.
- Reset (asynchronous, any time, including mid-burst): pointers and count=0, out_valid=0, out_data=0, out_mode=0, out_err=0, in_ready=1 one cycle after deassertion, err_count=0. In-flight entries are discarded.
- in_mode and in_data are sampled only on accept. X on unaccepted cycles has no effect.

Optional Feature:
- Macro: DES_PERM_ERRCNT_EN.
- Defined: err_count port exists. It increments on each accepted illegal-mode transaction, saturates at all-ones and clears only on reset.
- Undefined: port and counter are absent. out_err behaviour is unchanged.

Test Plan:
- IP: in_mode=0, in_data=64'h0000000000000001, out_ready=1 → next cycle out_valid=1, out_data=64'h0000008000000000, out_err=0.
- FP round-trip: mode=1, data=64'h0000008000000000 → out_data=64'h1. Random 64-bit values through IP then FP → original value.
- E and P: mode=2, data=64'h00000001 → out_data=64'h0000800000000002. Mode=3, data=64'h80000000 → out_data=64'h00800000.
- PC1/illegal: mode=4, data=64'h1 (parity bit) → out_data=0, out_err=0. Mode=6, data=all-ones → out_data=0, out_err=1, err_count increments 0→1 (with macro).
- Backpressure: out_ready=0, push FIFO_DEPTH items → in_ready=0, the extra in_valid is held off. Raise out_ready → entries drain in order, in_ready returns in the same cycle as the first pop.
- Reset mid-operation: buffer holding 2 entries, assert rst_n=0 between edges → out_valid=0 immediately. After release, a new IP transaction completes with latency 1 and no stale data.
